// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier family.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Ceiling log2, used to size the iteration counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_abs.sv
// Combinational conditional two's-complement negate.
// With neg=1 the most negative input maps onto itself, which read as
// unsigned is exactly its magnitude, so no overflow handling is needed.
module mult_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/mult_seq_param.sv
// Parametrised sequential shift-add multiplier, signed or unsigned per
// operation, with optional early termination once the remaining
// multiplier bits are zero. Handshake: start / busy / done.
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     b_shift;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_fix;
    logic [CW-1:0]        ctr;
    logic                 neg;

    mult_abs #(.W(WIDTH)) u_abs_a (
        .val (a),
        .neg (tc & a[WIDTH-1]),
        .res (a_abs)
    );

    mult_abs #(.W(WIDTH)) u_abs_b (
        .val (b),
        .neg (tc & b[WIDTH-1]),
        .res (b_abs)
    );

    mult_abs #(.W(2*WIDTH)) u_sign_fix (
        .val (acc),
        .neg (neg),
        .res (acc_fix)
    );

    assign b_shift = b_mag >> 1;
    assign a_ext   = {{WIDTH{1'b0}}, a_mag};
    assign busy    = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: CALC ends after the last bit, or early once the
    // remaining multiplier bits are all zero when EARLY_EXIT is enabled.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: begin
                if (ctr == LAST || (EARLY_EXIT != 0 && b_shift == '0))
                    state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch magnitudes on accept, shift-add in CALC, sign fix in FIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_mag   <= '0;
            b_mag   <= '0;
            acc     <= '0;
            ctr     <= '0;
            neg     <= 1'b0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_mag <= a_abs;
                        b_mag <= b_abs;
                        neg   <= tc & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        ctr   <= '0;
                    end
                end
                ST_CALC: begin
                    if (b_mag[0]) acc <= acc + (a_ext << ctr);
                    b_mag <= b_shift;
                    ctr   <= ctr + 1'b1;
                end
                ST_FIX: begin
                    product <= acc_fix;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
